videogen_timing_controller: RTL and testbench
=============================================

Name: videogen_timing_controller

Overview:
- Video timing sequencer for the videogen subsystem (index latch -> CLUT PROMs -> RGB registers).
- Generates H/V counters, blanking and sync for the pixel datapath.
- Drives the index-latch clear (nCLR) so blanked pixels resolve to palette entry 0.
- Applies CPU palette-bank changes only at vblank start (tear-free) and raises a one-cycle vblank interrupt pulse.

Parameters:
- H_TOTAL, 384, pixel clocks per line (count 0..H_TOTAL-1)
- H_ACTIVE, 288, visible pixels per line (0..H_ACTIVE-1)
- H_SYNC_START, 304, first HCOUNT with HSYNC asserted
- H_SYNC_WIDTH, 32, HSYNC length in pixel clocks
- V_TOTAL, 264, lines per frame
- V_ACTIVE, 224, visible lines
- V_SYNC_START, 240, first VCOUNT with VSYNC asserted
- V_SYNC_WIDTH, 3, VSYNC length in lines
- PIPE_DELAY, 2, datapath latency in clocks (index latch + RGB register), range 1..7

Ports:
- CLK_6MD, in, 1, pixel clock
- reset, in, 1, synchronous active-high reset
- enable, in, 1, clock enable; low = freeze all state
- bank_in, in, 1, requested palette bank (CPU register)
- pix_in, in, 8, pixel index from the tile/sprite mixer
- D, out, 8, index to videogen subsystem D
- nCLR, out, 1, index latch clear, active low
- BANK, out, 1, applied palette bank to videogen subsystem
- HCOUNT, out, 9, horizontal position
- VCOUNT, out, 9, vertical position
- HBLANK, out, 1, high outside active width (undelayed)
- VBLANK, out, 1, high outside active height (undelayed)
- SYNC, out, 1, composite sync, active low, delayed by PIPE_DELAY
- VBLANK_IRQ, out, 1, one-cycle pulse at vblank start

Behaviour:
- All state advances only on a CLK_6MD rising edge with enable=1. With reset=1, reset wins over enable.
- Reset values:
  - HCOUNT=0, VCOUNT=0, HBLANK=0, VBLANK=0
  - SYNC=1, nCLR=0, BANK=0, VBLANK_IRQ=0, D=0
  - sync delay line filled with 1 (inactive)
- Counters:
  - HCOUNT increments each enabled cycle and wraps at H_TOTAL-1 -> 0.
  - VCOUNT increments only on an HCOUNT wrap, and wraps at V_TOTAL-1 -> 0.
  - Both are 9-bit unsigned and never reach H_TOTAL or V_TOTAL.
- Registered flags, computed from the next counter values so each flag is coincident with its counts:
  - HBLANK = (HCOUNT >= H_ACTIVE)
  - VBLANK = (VCOUNT >= V_ACTIVE)
  - hsync_raw = HCOUNT in [H_SYNC_START, H_SYNC_START+H_SYNC_WIDTH)
  - vsync_raw = VCOUNT in [V_SYNC_START, V_SYNC_START+V_SYNC_WIDTH)
- Composite sync: SYNC = NOT(hsync_raw XOR vsync_raw), passed through a PIPE_DELAY-stage shift register so it aligns with the datapath RGB output.
- Blank clear: nCLR = NOT(HBLANK OR VBLANK), aligned with the pixel's HCOUNT/VCOUNT. The downstream index latch therefore holds 0 for every blanked pixel.
- D is pix_in registered one clock, with no gating; nCLR does the blanking.
- Bank update:
  - bank_in is sampled into BANK only on the cycle where the counters step to VCOUNT=V_ACTIVE, HCOUNT=0 (vblank start).
  - At all other times BANK holds its value.
  - If bank_in changes on that same edge, the value present at that edge is taken.
- VBLANK_IRQ is high for exactly one enabled cycle, coincident with the BANK update point. If enable drops, it holds its value until the next enabled edge.
- Reset mid-frame: on the next edge the counters are at 0,0, the IRQ is cleared, BANK=0, and the delay line is flushed to inactive.
- Wrap of both counters on the same edge: the frame restarts at 0,0 with VBLANK=0 and HBLANK=0.

Optional Feature:
- Macro: VIDEOGEN_TIMING_TEST_PATTERN_EN
- Defined: adds input pattern_en (1 bit).
  - When pattern_en=1, D = {HCOUNT[8:5], VCOUNT[7:4]}, registered: 16-pixel-wide vertical bars with a per-16-line variation.
  - When pattern_en=0, D = registered pix_in.
  - pattern_en is sampled each cycle; no frame alignment.
- Undefined: no pattern_en port; D is always the registered pix_in.

Test Plan:
- Reset, then 384*264 enabled cycles:
  - HCOUNT wraps 383 -> 0 exactly 264 times.
  - VCOUNT wraps 263 -> 0 once.
  - HBLANK high for 96 cycles per line; VBLANK high for 40 lines.
- Sync timing:
  - SYNC goes low PIPE_DELAY=2 clocks after the counters reach HCOUNT=304 on an active line.
  - Pulse width is 32 clocks.
  - During VCOUNT 240..242 the polarity inverts (serration).
- Bank and IRQ:
  - Set bank_in=1 at VCOUNT=100 -> BANK stays 0 until the counters reach VCOUNT=224, HCOUNT=0.
  - At that point BANK=1 and VBLANK_IRQ pulses exactly 1 cycle.
  - Toggle bank_in back to 0 on the same edge -> BANK=0 is captured.
- Blank clear and enable:
  - pix_in=0xA5 constant -> D=0xA5, nCLR=1 at HCOUNT 0..287, nCLR=0 at 288..383.
  - Hold enable=0 for 50 cycles mid-line -> all outputs frozen, then resume from the same HCOUNT.
- Reset mid-frame at VCOUNT=150, HCOUNT=200 with BANK=1:
  - Next cycle shows counters 0,0, BANK=0, nCLR=0, SYNC=1.
  - SYNC stays 1 for PIPE_DELAY cycles.
- With VIDEOGEN_TIMING_TEST_PATTERN_EN defined and pattern_en=1:
  - At HCOUNT=0x40, VCOUNT=0x30, the next cycle's D=0x23.
  - pattern_en=0 restores D=pix_in.

Source files
------------

// File: rtl/videogen_timing_controller.sv
// Video timing sequencer: H/V counters, blanking, delayed composite sync, index-latch clear and tear-free bank switch.
// Optional VIDEOGEN_TIMING_TEST_PATTERN_EN adds pattern_en, which replaces D with a counter-derived bar pattern.
module videogen_timing_controller #(
    parameter int H_TOTAL      = 384,
    parameter int H_ACTIVE     = 288,
    parameter int H_SYNC_START = 304,
    parameter int H_SYNC_WIDTH = 32,
    parameter int V_TOTAL      = 264,
    parameter int V_ACTIVE     = 224,
    parameter int V_SYNC_START = 240,
    parameter int V_SYNC_WIDTH = 3,
    parameter int PIPE_DELAY   = 2
) (
    input  logic       CLK_6MD,
    input  logic       reset,
    input  logic       enable,
    input  logic       bank_in,
    input  logic [7:0] pix_in,
`ifdef VIDEOGEN_TIMING_TEST_PATTERN_EN
    input  logic       pattern_en,
`endif
    output logic [7:0] D,
    output logic       nCLR,
    output logic       BANK,
    output logic [8:0] HCOUNT,
    output logic [8:0] VCOUNT,
    output logic       HBLANK,
    output logic       VBLANK,
    output logic       SYNC,
    output logic       VBLANK_IRQ
);

    localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_ACT    = 9'(H_ACTIVE);
    localparam logic [8:0] V_ACT    = 9'(V_ACTIVE);
    localparam logic [8:0] HS_START = 9'(H_SYNC_START);
    localparam logic [8:0] HS_END   = 9'(H_SYNC_START + H_SYNC_WIDTH);
    localparam logic [8:0] VS_START = 9'(V_SYNC_START);
    localparam logic [8:0] VS_END   = 9'(V_SYNC_START + V_SYNC_WIDTH);

    logic [8:0]            h_cnt;
    logic [8:0]            v_cnt;
    logic [8:0]            h_next;
    logic [8:0]            v_next;
    logic                  h_wrap;
    logic                  vblank_start;
    logic                  hblank_q;
    logic                  vblank_q;
    logic                  hsync_raw;
    logic                  vsync_raw;
    logic                  sync_comp;
    logic                  nclr_q;
    logic                  bank_q;
    logic                  irq_q;
    logic [7:0]            d_q;
    logic [7:0]            d_next;
    logic [PIPE_DELAY-1:0] sync_pipe;

    // Flags are registered from the next counter values so they line up with the counts they describe.
    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        h_next = h_wrap ? 9'd0 : h_cnt + 9'd1;
        v_next = v_cnt;
        if (h_wrap) begin
            v_next = (v_cnt == V_LAST) ? 9'd0 : v_cnt + 9'd1;
        end
        vblank_start = (h_next == 9'd0) && (v_next == V_ACT);
        // Serration falls out of the XOR: during vsync lines the hsync pulse flips polarity.
        sync_comp = ~(hsync_raw ^ vsync_raw);
    end

    always_comb begin
`ifdef VIDEOGEN_TIMING_TEST_PATTERN_EN
        d_next = pattern_en ? {h_cnt[8:5], v_cnt[7:4]} : pix_in;
`else
        d_next = pix_in;
`endif
    end

    always_ff @(posedge CLK_6MD) begin
        if (reset) begin
            h_cnt     <= 9'd0;
            v_cnt     <= 9'd0;
            hblank_q  <= 1'b0;
            vblank_q  <= 1'b0;
            hsync_raw <= 1'b0;
            vsync_raw <= 1'b0;
            nclr_q    <= 1'b0;
            bank_q    <= 1'b0;
            irq_q     <= 1'b0;
            d_q       <= 8'd0;
            sync_pipe <= '1;
        end else if (enable) begin
            h_cnt     <= h_next;
            v_cnt     <= v_next;
            hblank_q  <= (h_next >= H_ACT);
            vblank_q  <= (v_next >= V_ACT);
            hsync_raw <= (h_next >= HS_START) && (h_next < HS_END);
            vsync_raw <= (v_next >= VS_START) && (v_next < VS_END);
            nclr_q    <= ~((h_next >= H_ACT) | (v_next >= V_ACT));
            irq_q     <= vblank_start;
            if (vblank_start) begin
                bank_q <= bank_in;
            end
            d_q          <= d_next;
            sync_pipe[0] <= sync_comp;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                sync_pipe[i] <= sync_pipe[i-1];
            end
        end
    end

    assign HCOUNT     = h_cnt;
    assign VCOUNT     = v_cnt;
    assign HBLANK     = hblank_q;
    assign VBLANK     = vblank_q;
    assign nCLR       = nclr_q;
    assign BANK       = bank_q;
    assign VBLANK_IRQ = irq_q;
    assign D          = d_q;
    assign SYNC       = sync_pipe[PIPE_DELAY-1];

endmodule

// File: tb/tb_videogen_timing_controller.sv
// Bench for videogen_timing_controller: a reduced-geometry instance checked every cycle against a
// frame-position model, plus a default-geometry instance checked over its first line.
`timescale 1ns/1ps
module tb_videogen_timing_controller;

    localparam int HT = 48, HA = 36, HSS = 38, HSW = 4;
    localparam int VT = 40, VA = 30, VSS = 32, VSW = 3, PD = 2;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       bank_in = 1'b0;
    logic [7:0] pix_in = 8'd0;
    logic       pat_v = 1'b0;

    logic [7:0] s_d, f_d;
    logic       s_nclr, s_bank, s_hblank, s_vblank, s_sync, s_irq;
    logic       f_nclr, f_bank, f_hblank, f_vblank, f_sync, f_irq;
    logic [8:0] s_hcount, s_vcount, f_hcount, f_vcount;

    int tests = 0;
    int fails = 0;

    // model state: linear position in the frame plus registered side outputs
    int         m_pos;
    bit         m_bank, m_irq, m_fresh;
    logic [7:0] m_d;
    bit         m_sync[$];

    always #5 clk = ~clk;

    videogen_timing_controller #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_WIDTH(HSW),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_WIDTH(VSW),
        .PIPE_DELAY(PD)
    ) dut_small (
        .CLK_6MD(clk), .reset(reset), .enable(enable), .bank_in(bank_in), .pix_in(pix_in),
`ifdef VIDEOGEN_TIMING_TEST_PATTERN_EN
        .pattern_en(pat_v),
`endif
        .D(s_d), .nCLR(s_nclr), .BANK(s_bank), .HCOUNT(s_hcount), .VCOUNT(s_vcount),
        .HBLANK(s_hblank), .VBLANK(s_vblank), .SYNC(s_sync), .VBLANK_IRQ(s_irq)
    );

    videogen_timing_controller dut_full (
        .CLK_6MD(clk), .reset(reset), .enable(enable), .bank_in(bank_in), .pix_in(pix_in),
`ifdef VIDEOGEN_TIMING_TEST_PATTERN_EN
        .pattern_en(pat_v),
`endif
        .D(f_d), .nCLR(f_nclr), .BANK(f_bank), .HCOUNT(f_hcount), .VCOUNT(f_vcount),
        .HBLANK(f_hblank), .VBLANK(f_vblank), .SYNC(f_sync), .VBLANK_IRQ(f_irq)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // composite sync level for a frame position, straight from the sync window definitions
    function automatic bit comp_at(input int pos);
        int h, v;
        bit hs, vs;
        h  = pos % HT;
        v  = pos / HT;
        hs = (h >= HSS) && (h < HSS + HSW);
        vs = (v >= VSS) && (v < VSS + VSW);
        return !(hs ^ vs);
    endfunction

    task automatic model_edge(input bit rst, input bit en, input bit bk, input logic [7:0] px);
        logic [8:0] hh, vv;
        if (rst) begin
            m_pos   = 0;
            m_bank  = 1'b0;
            m_irq   = 1'b0;
            m_d     = 8'd0;
            m_fresh = 1'b1;
            m_sync.delete();
            for (int i = 0; i < PD; i++) m_sync.push_back(1'b1);
        end else if (en) begin
            m_sync.push_front(comp_at(m_pos));
            void'(m_sync.pop_back());
            hh  = 9'(m_pos % HT);
            vv  = 9'(m_pos / HT);
            m_d = pat_v ? {hh[8:5], vv[7:4]} : px;
            m_pos = (m_pos + 1) % FRAME;
            if (m_pos == VA * HT) begin
                m_bank = bk;
                m_irq  = 1'b1;
            end else begin
                m_irq = 1'b0;
            end
            m_fresh = 1'b0;
        end
    endtask

    task automatic check_small();
        int h, v;
        h = m_pos % HT;
        v = m_pos / HT;
        check("HCOUNT", 16'(s_hcount), 16'(h));
        check("VCOUNT", 16'(s_vcount), 16'(v));
        check("HBLANK", 16'(s_hblank), 16'(h >= HA));
        check("VBLANK", 16'(s_vblank), 16'(v >= VA));
        check("nCLR", 16'(s_nclr), 16'((!m_fresh) && (h < HA) && (v < VA)));
        check("SYNC", 16'(s_sync), 16'(m_sync[PD-1]));
        check("BANK", 16'(s_bank), 16'(m_bank));
        check("IRQ", 16'(s_irq), 16'(m_irq));
        check("D", 16'(s_d), 16'(m_d));
    endtask

    task automatic cycle(input bit rst, input bit en, input bit bk, input logic [7:0] px);
        reset   = rst;
        enable  = en;
        bank_in = bk;
        pix_in  = px;
        @(posedge clk);
        model_edge(rst, en, bk, px);
        #1;
        check_small();
    endtask

    initial begin
        int         hwraps, vwraps, hb_cnt, vb_cnt, irq_cnt, n, hc;
        logic [8:0] prev_h, prev_v;
        bit         bk;

        // reset asserted together with enable low: reset still wins
        cycle(1'b1, 1'b0, 1'b1, 8'h5A);
        check("full_rst_HCOUNT", 16'(f_hcount), 16'd0);
        check("full_rst_VCOUNT", 16'(f_vcount), 16'd0);
        check("full_rst_HBLANK", 16'(f_hblank), 16'd0);
        check("full_rst_VBLANK", 16'(f_vblank), 16'd0);
        check("full_rst_SYNC", 16'(f_sync), 16'd1);
        check("full_rst_nCLR", 16'(f_nclr), 16'd0);
        check("full_rst_BANK", 16'(f_bank), 16'd0);
        check("full_rst_IRQ", 16'(f_irq), 16'd0);
        check("full_rst_D", 16'(f_d), 16'd0);

        // one full frame, continuously enabled; bank request raised mid-frame
        hwraps = 0; vwraps = 0; hb_cnt = 0; vb_cnt = 0; irq_cnt = 0;
        prev_h = s_hcount;
        prev_v = s_vcount;
        for (int i = 0; i < FRAME; i++) begin
`ifdef VIDEOGEN_TIMING_TEST_PATTERN_EN
            pat_v = (i == 64);
`endif
            cycle(1'b0, 1'b1, (i >= 10 * HT), 8'($urandom));
            if (prev_h == 9'(HT - 1) && s_hcount == 9'd0) hwraps++;
            if (prev_v == 9'(VT - 1) && s_vcount == 9'd0) vwraps++;
            if (s_hblank) hb_cnt++;
            if (s_vblank) vb_cnt++;
            if (s_irq) irq_cnt++;
            prev_h = s_hcount;
            prev_v = s_vcount;
            if (i < 345) begin
                hc = i + 1;
                check("full_HCOUNT", 16'(f_hcount), 16'(hc));
                check("full_VCOUNT", 16'(f_vcount), 16'd0);
                check("full_HBLANK", 16'(f_hblank), 16'(hc >= 288));
                check("full_VBLANK", 16'(f_vblank), 16'd0);
                check("full_nCLR", 16'(f_nclr), 16'(hc < 288));
                check("full_SYNC", 16'(f_sync), 16'(!(hc >= 306 && hc < 338)));
            end
`ifdef VIDEOGEN_TIMING_TEST_PATTERN_EN
            if (i == 64) check("full_pattern_D", 16'(f_d), 16'h0020);
`endif
        end
        pat_v = 1'b0;
        check("hcount_wraps", 16'(hwraps), 16'(VT));
        check("vcount_wraps", 16'(vwraps), 16'd1);
        check("hblank_cycles", 16'(hb_cnt), 16'((HT - HA) * VT));
        check("vblank_cycles", 16'(vb_cnt), 16'((VT - VA) * HT));
        check("irq_pulses", 16'(irq_cnt), 16'd1);

        // second frame: constant pixel, a 50-cycle freeze mid-line, bank_in dropped exactly on the capture edge
        for (int k = 0; k < FRAME + 50; k++) begin
            bk = ((m_pos + 1) % FRAME == VA * HT) ? 1'b0 : 1'b1;
            cycle(1'b0, !(k >= 250 && k < 300), bk, 8'hA5);
            if (k >= 250 && k < 300) check("freeze_HCOUNT", 16'(s_hcount), 16'(250 % HT));
            if (m_pos == VA * HT && s_vblank) check("bank_toggle_edge", 16'(s_bank), 16'd0);
        end

        // randomized enable, bank requests and pixels
        bk = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if ($urandom_range(0, 199) == 0) bk = !bk;
`ifdef VIDEOGEN_TIMING_TEST_PATTERN_EN
            if ($urandom_range(0, 99) == 0) pat_v = !pat_v;
`endif
            cycle(1'b0, ($urandom_range(0, 9) != 0), bk, 8'($urandom));
        end
        pat_v = 1'b0;

        // mid-frame reset with BANK=1
        n = 0;
        while (!(m_bank && m_pos == 20 * HT + 30) && n < 3 * FRAME) begin
            cycle(1'b0, 1'b1, 1'b1, 8'($urandom));
            n++;
        end
        check("pre_reset_BANK", 16'(s_bank), 16'd1);
        check("pre_reset_VCOUNT", 16'(s_vcount), 16'd20);
        cycle(1'b1, 1'b1, 1'b1, 8'($urandom));
        check("mid_rst_HCOUNT", 16'(s_hcount), 16'd0);
        check("mid_rst_VCOUNT", 16'(s_vcount), 16'd0);
        check("mid_rst_BANK", 16'(s_bank), 16'd0);
        check("mid_rst_nCLR", 16'(s_nclr), 16'd0);
        check("mid_rst_SYNC", 16'(s_sync), 16'd1);
        for (int i = 0; i < PD + 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'($urandom));
            check("post_rst_SYNC", 16'(s_sync), 16'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
